// File: rtl/disp_word_src.sv
// disp_word_src: selects one of four CPU-derived 32-bit words for a
// seven-segment display. Two debounced pushbuttons step the page and
// freeze the view. Halting the CPU forces the frozen view.
module disp_word_src #(
    parameter int unsigned DEB_CYCLES = 1000000
) (
    input  logic        CLK_100MHZ,
    input  logic        RST,
    input  logic        BTN_NEXT,
    input  logic        BTN_FREEZE,
    input  logic [31:0] pc_val,
    input  logic [31:0] wdat,
    input  logic        wen,
    input  logic        halt,
    output logic [31:0] display_digits,
    output logic [1:0]  page,
    output logic        frozen
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

    // Bit 0 carries BTN_NEXT, bit 1 carries BTN_FREEZE.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb_lvl;
    logic [CW-1:0] deb_cnt [2];
    logic [1:0]    deb_flip;
    logic          press_next;
    logic          press_freeze;

    logic [31:0]   last_wdat;
    logic [31:0]   wcount;
    logic [31:0]   ccount;
    logic [31:0]   snap [4];

    logic [1:0]    page_nx;
    logic          frozen_nx;
    logic          freeze_edge;
    logic [31:0]   last_wdat_nx;
    logic [31:0]   wcount_nx;
    logic [31:0]   ccount_nx;
    logic [31:0]   live_word;

    // Two-flop synchronizers for both raw buttons.
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {BTN_FREEZE, BTN_NEXT};
            sync2 <= sync1;
        end
    end

    // Flip when the differing level has lasted DEB_CYCLES cycles; only rising flips are presses.
    always_comb begin
        deb_flip = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            deb_flip[i] = (sync2[i] != deb_lvl[i]) && (deb_cnt[i] == CNT_MAX);
        end
        press_next   = deb_flip[0] & sync2[0];
        press_freeze = deb_flip[1] & sync2[1];
    end

    // Debounce counters: restart whenever the synchronized level agrees with the accepted one.
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            deb_lvl <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb_lvl[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_flip[i]) begin
                    deb_lvl[i] <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + CW'(1);
                end
            end
        end
    end

    // Next-state values of page, freeze flag and the four display sources.
    always_comb begin
        page_nx      = page + {1'b0, press_next};
        frozen_nx    = halt | (frozen ^ press_freeze);
        freeze_edge  = frozen_nx & ~frozen;
        last_wdat_nx = wen ? wdat : last_wdat;
        wcount_nx    = (wen && (wcount != '1)) ? wcount + 32'd1 : wcount;
        ccount_nx    = (!halt && (ccount != '1)) ? ccount + 32'd1 : ccount;
        case (page_nx)
            2'd0:    live_word = pc_val;
            2'd1:    live_word = last_wdat_nx;
            2'd2:    live_word = wcount_nx;
            default: live_word = ccount_nx;
        endcase
    end

    // Page, freeze flag and source registers.
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            page      <= '0;
            frozen    <= 1'b0;
            last_wdat <= '0;
            wcount    <= '0;
            ccount    <= '0;
        end else begin
            page      <= page_nx;
            frozen    <= frozen_nx;
            last_wdat <= last_wdat_nx;
            wcount    <= wcount_nx;
            ccount    <= ccount_nx;
        end
    end

    // Snapshot captures next-state sources on the edge where freezing begins.
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            for (int unsigned i = 0; i < 4; i++) begin
                snap[i] <= '0;
            end
        end else if (freeze_edge) begin
            snap[0] <= pc_val;
            snap[1] <= last_wdat_nx;
            snap[2] <= wcount_nx;
            snap[3] <= ccount_nx;
        end
    end

    // Display register; on the freeze edge the live word equals what the snapshot is loading.
    always_ff @(posedge CLK_100MHZ) begin
        if (RST) begin
            display_digits <= '0;
        end else if (frozen_nx && frozen) begin
            display_digits <= snap[page_nx];
        end else begin
            display_digits <= live_word;
        end
    end

endmodule

// File: tb/tb_disp_word_src.sv
// Testbench for disp_word_src with a short debounce window.
module tb_disp_word_src;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_next;
    logic        btn_freeze;
    logic [31:0] pc_val;
    logic [31:0] wdat;
    logic        wen;
    logic        halt;
    logic [31:0] display_digits;
    logic [1:0]  page;
    logic        frozen;

    disp_word_src #(.DEB_CYCLES(DEB)) dut (
        .CLK_100MHZ     (clk),
        .RST            (rst),
        .BTN_NEXT       (btn_next),
        .BTN_FREEZE     (btn_freeze),
        .pc_val         (pc_val),
        .wdat           (wdat),
        .wen            (wen),
        .halt           (halt),
        .display_digits (display_digits),
        .page           (page),
        .frozen         (frozen)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit          m_s1 [2];
    bit          m_s2 [2];
    bit          m_deb [2];
    bit          m_win [2][DEB];
    int          m_page;
    bit          m_frozen;
    logic [31:0] m_lw, m_wc, m_cc, m_disp;
    logic [31:0] m_snap [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // A level is accepted once the last DEB synchronized samples all disagree with it.
    task automatic deb_model(input int b, input bit raw, output bit pulse);
        bit all_diff;
        all_diff = 1'b1;
        pulse = 1'b0;
        for (int i = DEB - 1; i > 0; i--) m_win[b][i] = m_win[b][i-1];
        m_win[b][0] = m_s2[b];
        for (int i = 0; i < DEB; i++) if (m_win[b][i] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) begin
            m_deb[b] = !m_deb[b];
            pulse = m_deb[b];
        end
        m_s2[b] = m_s1[b];
        m_s1[b] = raw;
    endtask

    task automatic model_step();
        bit pn, pf;
        logic [31:0] src [4];
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                m_s1[b] = 0; m_s2[b] = 0; m_deb[b] = 0;
                for (int i = 0; i < DEB; i++) m_win[b][i] = 0;
            end
            m_page = 0; m_frozen = 0;
            m_lw = 0; m_wc = 0; m_cc = 0; m_disp = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 0;
            return;
        end
        deb_model(0, btn_next, pn);
        deb_model(1, btn_freeze, pf);
        if (wen) m_lw = wdat;
        if (wen && m_wc != 32'hFFFFFFFF) m_wc = m_wc + 1;
        if (!halt && m_cc != 32'hFFFFFFFF) m_cc = m_cc + 1;
        m_page = (m_page + int'(pn)) % 4;
        src = '{pc_val, m_lw, m_wc, m_cc};
        if (halt) begin
            if (!m_frozen) m_snap = src;
            m_frozen = 1;
        end else if (pf) begin
            m_frozen = !m_frozen;
            if (m_frozen) m_snap = src;
        end
        m_disp = m_frozen ? m_snap[m_page] : src[m_page];
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("mdl_page", 32'(page), 32'(m_page));
        check("mdl_frozen", 32'(frozen), 32'(m_frozen));
        check("mdl_display", display_digits, m_disp);
    endtask

    task automatic press(input bit nx, input bit fz, input bit wen_at_pulse, input logic [31:0] wd);
        btn_next = nx;
        btn_freeze = fz;
        for (int i = 1; i <= 8; i++) begin
            if (wen_at_pulse && i == 6) begin
                wen = 1'b1;
                wdat = wd;
            end
            tick();
            wen = 1'b0;
        end
        btn_next = 1'b0;
        btn_freeze = 1'b0;
        repeat (8) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wen_pulse(input logic [31:0] wd);
        wen = 1'b1;
        wdat = wd;
        tick();
        wen = 1'b0;
        tick();
    endtask

    typedef struct {
        bit          nx;
        bit          fz;
        bit          we;
        logic [31:0] wd;
        logic [1:0]  e_page;
        bit          e_frz;
        bit          chk_d;
        logic [31:0] e_disp;
    } vec_t;

    vec_t tbl [13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1);
    end

    initial begin
        int changes, at_tick;
        logic [1:0] prev;

        rst = 1'b1; btn_next = 0; btn_freeze = 0;
        pc_val = 0; wdat = 0; wen = 0; halt = 0;

        // Reset state
        tick();
        tick();
        check("rst_page", 32'(page), 32'd0);
        check("rst_frozen", 32'(frozen), 32'd0);
        check("rst_display", display_digits, 32'd0);
        rst = 1'b0;

        // Reset in the middle of a debounce aborts it
        btn_next = 1'b1;
        repeat (4) tick();
        rst = 1'b1;
        btn_next = 1'b0;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        check("abort_page", 32'(page), 32'd0);

        // Bounce then stable hold
        pc_val = 32'h00000040;
        for (int i = 0; i < 20; i++) begin
            btn_next = ((i / 2) % 2) == 0;
            tick();
            check("bounce_page", 32'(page), 32'd0);
        end
        btn_next = 1'b1;
        changes = 0;
        at_tick = 0;
        prev = page;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (page != prev) begin
                changes++;
                if (at_tick == 0) at_tick = i;
                prev = page;
            end
        end
        check("bounce_changes", 32'(changes), 32'd1);
        check("bounce_latency", 32'(at_tick), 32'd6);
        check("bounce_page_final", 32'(page), 32'd1);
        btn_next = 1'b0;
        repeat (8) tick();

        // Page wrap, writeback capture, simultaneous presses
        do_reset();
        tbl[0]  = '{1, 0, 0, 32'h0,        2'd1, 0, 1, 32'h00000000};
        tbl[1]  = '{1, 0, 0, 32'h0,        2'd2, 0, 1, 32'h00000000};
        tbl[2]  = '{1, 0, 0, 32'h0,        2'd3, 0, 0, 32'h0};
        tbl[3]  = '{1, 0, 0, 32'h0,        2'd0, 0, 1, 32'h00000040};
        tbl[4]  = '{0, 0, 1, 32'hDEADBEEF, 2'd0, 0, 1, 32'h00000040};
        tbl[5]  = '{0, 0, 1, 32'h12345678, 2'd0, 0, 1, 32'h00000040};
        tbl[6]  = '{1, 0, 0, 32'h0,        2'd1, 0, 1, 32'h12345678};
        tbl[7]  = '{1, 0, 0, 32'h0,        2'd2, 0, 1, 32'h00000002};
        tbl[8]  = '{1, 1, 0, 32'h0,        2'd3, 1, 0, 32'h0};
        tbl[9]  = '{0, 1, 0, 32'h0,        2'd3, 0, 0, 32'h0};
        tbl[10] = '{1, 0, 0, 32'h0,        2'd0, 0, 1, 32'h00000040};
        tbl[11] = '{1, 0, 0, 32'h0,        2'd1, 0, 1, 32'h12345678};
        tbl[12] = '{1, 0, 0, 32'h0,        2'd2, 0, 1, 32'h00000002};
        for (int i = 0; i < 13; i++) begin
            if (tbl[i].nx || tbl[i].fz) press(tbl[i].nx, tbl[i].fz, tbl[i].we, tbl[i].wd);
            else if (tbl[i].we) wen_pulse(tbl[i].wd);
            check($sformatf("tbl%0d_page", i), 32'(page), 32'(tbl[i].e_page));
            check($sformatf("tbl%0d_frozen", i), 32'(frozen), 32'(tbl[i].e_frz));
            if (tbl[i].chk_d) check($sformatf("tbl%0d_display", i), display_digits, tbl[i].e_disp);
        end

        // Freeze coinciding with a writeback
        press(0, 1, 1, 32'hCAFEF00D);
        check("frz_frozen", 32'(frozen), 32'd1);
        check("frz_wcount", display_digits, 32'd3);
        pc_val = 32'h00000080;
        for (int k = 1; k <= 3; k++) begin
            wen_pulse(32'h11111111 * k);
            check("frz_hold", display_digits, 32'd3);
        end
        press(1, 0, 0, 32'h0);
        press(1, 0, 0, 32'h0);
        check("frz_snap_pc", display_digits, 32'h00000040);
        press(1, 0, 0, 32'h0);
        check("frz_snap_wdat", display_digits, 32'hCAFEF00D);
        press(1, 0, 0, 32'h0);
        check("frz_snap_wcount", display_digits, 32'd3);
        press(0, 1, 0, 32'h0);
        check("unfrz_frozen", 32'(frozen), 32'd0);
        check("unfrz_wcount", display_digits, 32'd6);

        // Halt forces freeze and stops the cycle counter
        do_reset();
        repeat (100) tick();
        halt = 1'b1;
        tick();
        check("halt_frozen", 32'(frozen), 32'd1);
        press(1, 0, 0, 32'h0);
        press(1, 0, 0, 32'h0);
        press(1, 0, 0, 32'h0);
        check("halt_page", 32'(page), 32'd3);
        check("halt_ccount", display_digits, 32'd100);
        press(0, 1, 0, 32'h0);
        check("halt_ignore_frz", 32'(frozen), 32'd1);
        halt = 1'b0;
        tick();
        check("unhalt_frozen", 32'(frozen), 32'd1);
        check("unhalt_display", display_digits, 32'd100);
        press(0, 1, 0, 32'h0);
        check("resume_frozen", 32'(frozen), 32'd0);
        check("resume_ccount", display_digits, 32'd117);

        // Write counter saturation, then reset clears outputs
        do_reset();
        press(1, 0, 0, 32'h0);
        press(1, 0, 0, 32'h0);
        force dut.wcount = 32'hFFFFFFFE;
        m_wc = 32'hFFFFFFFE;
        tick();
        release dut.wcount;
        repeat (3) wen_pulse(32'h5A5A5A5A);
        check("sat_wcount", display_digits, 32'hFFFFFFFF);
        rst = 1'b1;
        tick();
        check("sat_rst_page", 32'(page), 32'd0);
        check("sat_rst_frozen", 32'(frozen), 32'd0);
        check("sat_rst_display", display_digits, 32'd0);
        rst = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 49) == 0) halt = !halt;
            if ($urandom_range(0, 4) == 0) btn_next = !btn_next;
            if ($urandom_range(0, 4) == 0) btn_freeze = !btn_freeze;
            wen = $urandom_range(0, 1) == 1;
            wdat = $urandom;
            pc_val = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
